// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg
//   Shared definitions for the UART receive-side packet path: parser state
//   encoding, default framing constants, packet length, the opcode values
//   understood by command consumers, and the running-checksum helper.
package uart_pkt_pkg;

  // Parser states, in packet byte order.
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_OP    = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DH    = 3'd3,
    ST_DL    = 3'd4,
    ST_CK    = 3'd5,
    ST_CHECK = 3'd6,
    ST_HOLD  = 3'd7
  } pkt_state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF       = 8'hA5;
  localparam logic [15:0] TIMEOUT_TICKS_DEF   = 16'd480;
  localparam logic [7:0]  STOP_WAIT_TICKS_DEF = 8'd24;

  // sync, opcode, address, data high, data low, checksum
  localparam int unsigned PKT_LEN = 32'd6;

  // Opcodes understood by command consumers.
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  // Modulo-256 running checksum; a good packet sums to zero over
  // opcode..checksum.
  function automatic logic [7:0] cksum_add(input logic [7:0] sum,
                                           input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_rx_tick_timer.sv
// uart_rx_tick_timer
//   Clearable, enable-gated up-counter that saturates at TERM.
//   o_tc flags the terminal count one cycle early when the TERM-th enable is
//   being applied, so a consumer can act on the same edge the count lands.
// Ports:
//   i_clk   clock
//   i_rst_n asynchronous active-low reset
//   i_clr   synchronous clear (wins over i_en, suppresses o_tc)
//   i_en    count enable (one tick)
//   o_tc    terminal count reached (or being reached this cycle)
module uart_rx_tick_timer
  import uart_pkt_pkg::*;
#(
  parameter int unsigned      WIDTH = 32'd16,
  parameter logic [WIDTH-1:0] TERM  = '1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TERM_M1 = TERM - ONE;

  logic [WIDTH-1:0] r_cnt;

  // Tick counter: cleared on request, holds at TERM instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = !i_clr && ((r_cnt == TERM) || (i_en && (r_cnt == TERM_M1)));

endmodule

// File: rtl/uart_rx_pkt_ctl.sv
// uart_rx_pkt_ctl
//   Assembles 6-byte command packets (sync, op, addr, data hi, data lo,
//   checksum) from the UART receive byte stream, rejects packets on framing,
//   inter-byte timeout or checksum error, and presents good commands on a
//   valid/ready handshake. All outputs come straight from flops.
// Ports:
//   clk_rx, rst_clk_rx_n          clock, async active-low reset
//   baud_x16_en                   16x oversample tick
//   rx_data, rx_data_rdy, frm_err byte stream from the UART receiver
//   cmd_valid, cmd_ready          command handshake
//   cmd_op, cmd_addr, cmd_wdata   command fields, stable while cmd_valid
//   err_frame/timeout/cksum/overrun  one-clock error pulses
//   busy                          parser is not hunting for sync
module uart_rx_pkt_ctl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_TICKS   = TIMEOUT_TICKS_DEF,
  parameter logic [7:0]  STOP_WAIT_TICKS = STOP_WAIT_TICKS_DEF
) (
  input  logic        clk_rx,
  input  logic        rst_clk_rx_n,
  input  logic        baud_x16_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  input  logic        frm_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        err_frame,
  output logic        err_timeout,
  output logic        err_cksum,
  output logic        err_overrun,
  output logic        busy
);

  pkt_state_e  r_state;
  logic        r_rdy_q, r_ferr_q;
  logic [7:0]  r_sum, r_op, r_addr, r_dh, r_dl;
  logic [7:0]  r_cmd_op, r_cmd_addr;
  logic [15:0] r_cmd_wdata;
  logic        r_cmd_valid, r_busy;
  logic        r_err_frame, r_err_timeout, r_err_cksum, r_err_overrun;

  logic w_byte_ev, w_ferr_ev, w_in_pkt, w_in_check, w_to_tc, w_sw_tc;

  // Only rising edges act; a level held high is never seen twice.
  assign w_byte_ev  = rx_data_rdy & ~r_rdy_q;
  assign w_ferr_ev  = frm_err & ~r_ferr_q;
  assign w_in_pkt   = (r_state inside {ST_OP, ST_ADDR, ST_DH, ST_DL, ST_CK});
  assign w_in_check = (r_state == ST_CHECK);

  // Previous-cycle copies of the receiver strobes for edge detection.
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      r_rdy_q  <= 1'b0;
      r_ferr_q <= 1'b0;
    end else begin
      r_rdy_q  <= rx_data_rdy;
      r_ferr_q <= frm_err;
    end
  end

  // Inter-byte gap timer: restarts on every byte, idle outside OP..CK.
  uart_rx_tick_timer #(.WIDTH(32'd16), .TERM(TIMEOUT_TICKS)) u_to_timer (
    .i_clk   (clk_rx),
    .i_rst_n (rst_clk_rx_n),
    .i_clr   (w_byte_ev | ~w_in_pkt),
    .i_en    (baud_x16_en & w_in_pkt),
    .o_tc    (w_to_tc)
  );

  // Stop-bit wait after the checksum byte, so a late frm_err can still
  // reject the packet before it is released.
  uart_rx_tick_timer #(.WIDTH(32'd8), .TERM(STOP_WAIT_TICKS)) u_sw_timer (
    .i_clk   (clk_rx),
    .i_rst_n (rst_clk_rx_n),
    .i_clr   (~w_in_check),
    .i_en    (baud_x16_en & w_in_check),
    .o_tc    (w_sw_tc)
  );

  // Packet parser FSM with registered command fields, status and errors.
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      r_state       <= ST_HUNT;
      r_sum         <= 8'h00;
      r_op          <= 8'h00;
      r_addr        <= 8'h00;
      r_dh          <= 8'h00;
      r_dl          <= 8'h00;
      r_cmd_op      <= 8'h00;
      r_cmd_addr    <= 8'h00;
      r_cmd_wdata   <= 16'h0000;
      r_cmd_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_cksum   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_cksum   <= 1'b0;
      r_err_overrun <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_byte_ev && (rx_data == SYNC_BYTE)) begin
            r_state <= ST_OP;
            r_sum   <= 8'h00;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_HUNT;
            r_busy  <= 1'b0;
          end
        end
        ST_OP, ST_ADDR, ST_DH, ST_DL, ST_CK: begin
          // Framing beats a byte, a byte beats the timeout.
          if (w_ferr_ev) begin
            r_state     <= ST_HUNT;
            r_busy      <= 1'b0;
            r_err_frame <= 1'b1;
          end else if (w_byte_ev) begin
            r_sum <= cksum_add(r_sum, rx_data);
            case (r_state)
              ST_OP:   begin r_op   <= rx_data; r_state <= ST_ADDR; end
              ST_ADDR: begin r_addr <= rx_data; r_state <= ST_DH;   end
              ST_DH:   begin r_dh   <= rx_data; r_state <= ST_DL;   end
              ST_DL:   begin r_dl   <= rx_data; r_state <= ST_CK;   end
              // checksum byte only contributes to the sum
              default: begin r_state <= ST_CHECK; end
            endcase
          end else if (w_to_tc) begin
            r_state       <= ST_HUNT;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b1;
          end else begin
            r_state <= r_state;
          end
        end
        ST_CHECK: begin
          if (w_ferr_ev) begin
            r_state     <= ST_HUNT;
            r_busy      <= 1'b0;
            r_err_frame <= 1'b1;
          end else if (w_sw_tc) begin
            if (r_sum == 8'h00) begin
              r_state     <= ST_HOLD;
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= r_op;
              r_cmd_addr  <= r_addr;
              r_cmd_wdata <= {r_dh, r_dl};
            end else begin
              r_state     <= ST_HUNT;
              r_busy      <= 1'b0;
              r_err_cksum <= 1'b1;
            end
          end else begin
            r_state <= ST_CHECK;
          end
        end
        ST_HOLD: begin
          // Any byte here is lost, even one arriving with the transfer.
          r_err_overrun <= w_byte_ev;
          if (cmd_ready) begin
            r_state     <= ST_HUNT;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state     <= ST_HUNT;
          r_cmd_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_op      = r_cmd_op;
  assign cmd_addr    = r_cmd_addr;
  assign cmd_wdata   = r_cmd_wdata;
  assign err_frame   = r_err_frame;
  assign err_timeout = r_err_timeout;
  assign err_cksum   = r_err_cksum;
  assign err_overrun = r_err_overrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_pkt_ctl.sv
// tb_uart_rx_pkt_ctl
//   Drives byte streams into uart_rx_pkt_ctl and compares the commands and
//   error pulses it produces with a stream-level packet model.
module tb_uart_rx_pkt_ctl;
  import uart_pkt_pkg::*;

  logic        clk_rx = 1'b0;
  logic        rst_clk_rx_n = 1'b0;
  logic        baud_x16_en = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_rdy = 1'b0;
  logic        frm_err = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_op, cmd_addr;
  logic [15:0] cmd_wdata;
  logic        err_frame, err_timeout, err_cksum, err_overrun, busy;

  uart_rx_pkt_ctl dut (
    .clk_rx       (clk_rx),
    .rst_clk_rx_n (rst_clk_rx_n),
    .baud_x16_en  (baud_x16_en),
    .rx_data      (rx_data),
    .rx_data_rdy  (rx_data_rdy),
    .frm_err      (frm_err),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .err_frame    (err_frame),
    .err_timeout  (err_timeout),
    .err_cksum    (err_cksum),
    .err_overrun  (err_overrun),
    .busy         (busy)
  );

  always #5 clk_rx = ~clk_rx;

  // Oversample tick every second clock, changed well clear of the edge.
  initial forever begin
    @(posedge clk_rx);
    #3;
    baud_x16_en = ~baud_x16_en;
  end

  int n_tests = 0;
  int n_fail  = 0;

  int cnt_frame = 0, cnt_to = 0, cnt_ck = 0, cnt_ovr = 0;
  int cnt_wide = 0, cnt_unstable = 0;
  int b_frame, b_to, b_ck, b_ovr;
  logic [3:0]  prev_err = 4'h0;
  logic        hold_watch = 1'b0;
  logic [31:0] hold_snap = 32'h0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  sent_q[$];
  int          exp_ck;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk_rx) begin
    if (rst_clk_rx_n) begin
      if (cmd_valid && cmd_ready) got_q.push_back({cmd_op, cmd_addr, cmd_wdata});
      if (err_frame)   cnt_frame++;
      if (err_timeout) cnt_to++;
      if (err_cksum)   cnt_ck++;
      if (err_overrun) cnt_ovr++;
      if (|({err_frame, err_timeout, err_cksum, err_overrun} & prev_err)) cnt_wide++;
      if (hold_watch && (!cmd_valid || ({cmd_op, cmd_addr, cmd_wdata} != hold_snap)))
        cnt_unstable++;
    end
    prev_err = {err_frame, err_timeout, err_cksum, err_overrun};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_rx);
    #1;
  endtask

  // One received byte: rdy high 30 clocks, optional frm_err 32 clocks after rise.
  task automatic send_byte(input logic [7:0] b, input bit ferr, input int gap, input bit rec);
    rx_data = b;
    rx_data_rdy = 1'b1;
    repeat (30) step();
    rx_data_rdy = 1'b0;
    repeat (2) step();
    frm_err = ferr;
    repeat (2) step();
    frm_err = 1'b0;
    repeat (gap) step();
    if (rec) sent_q.push_back(b);
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] ad, input logic [15:0] wd,
                          input logic [7:0] ck, input bit rec);
    send_byte(SYNC_BYTE_DEF, 1'b0, 4, rec);
    send_byte(op, 1'b0, 4, rec);
    send_byte(ad, 1'b0, 4, rec);
    send_byte(wd[15:8], 1'b0, 4, rec);
    send_byte(wd[7:0], 1'b0, 4, rec);
    send_byte(ck, 1'b0, 60, rec);
  endtask

  function automatic logic [7:0] good_ck(input logic [7:0] op, input logic [7:0] ad,
                                         input logic [15:0] wd);
    return 8'h00 - (op + ad + wd[15:8] + wd[7:0]);
  endfunction

  // Stream model: find sync, take the next five bytes, zero sum is a command.
  task automatic model_stream();
    int i;
    logic [7:0] s;
    i = 0;
    while (i < sent_q.size()) begin
      if (sent_q[i] == SYNC_BYTE_DEF && (i + int'(PKT_LEN)) <= sent_q.size()) begin
        s = 8'h00;
        for (int k = 1; k < int'(PKT_LEN); k++) s = s + sent_q[i+k];
        if (s == 8'h00) exp_q.push_back({sent_q[i+1], sent_q[i+2], sent_q[i+3], sent_q[i+4]});
        else exp_ck++;
        i = i + int'(PKT_LEN);
      end else begin
        i = i + 1;
      end
    end
    sent_q.delete();
  endtask

  task automatic mark();
    b_frame = cnt_frame; b_to = cnt_to; b_ck = cnt_ck; b_ovr = cnt_ovr;
    got_q.delete(); exp_q.delete(); sent_q.delete();
    exp_ck = 0;
  endtask

  task automatic verify(input string tag, input int e_frame, input int e_to, input int e_ovr);
    int n;
    model_stream();
    chk({tag, ".ncmd"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".cmd"}, got_q[i], exp_q[i]);
    chk({tag, ".cksum"},   32'(cnt_ck - b_ck),       32'(exp_ck));
    chk({tag, ".frame"},   32'(cnt_frame - b_frame), 32'(e_frame));
    chk({tag, ".timeout"}, 32'(cnt_to - b_to),       32'(e_to));
    chk({tag, ".overrun"}, 32'(cnt_ovr - b_ovr),     32'(e_ovr));
    chk({tag, ".busy"},    32'(busy),                32'd0);
    chk({tag, ".pulsew"},  32'(cnt_wide),            32'd0);
  endtask

  initial begin
    int ticks;
    bit seen;
    logic [7:0]  op, ad, ck;
    logic [15:0] wd;

    repeat (4) step();
    chk("rst.outs", {cmd_valid, busy, err_frame, err_timeout, err_cksum, err_overrun}, 32'd0);
    chk("rst.fields", {cmd_op, cmd_addr, cmd_wdata}, 32'd0);
    rst_clk_rx_n = 1'b1;
    repeat (4) step();

    // Good packet
    cmd_ready = 1'b1;
    mark();
    send_pkt(OP_WRITE, 8'h10, 16'h1234, 8'hA9, 1'b1);
    chk("good.ncmd_direct", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("good.fields", got_q[0], 32'h0110_1234);
    verify("good", 0, 0, 0);

    // Bad checksum, then a good packet
    mark();
    send_pkt(OP_WRITE, 8'h10, 16'h1234, 8'hAA, 1'b1);
    chk("badck.valid", 32'(cmd_valid), 32'd0);
    chk("badck.cnt", 32'(cnt_ck - b_ck), 32'd1);
    send_pkt(OP_READ, 8'h22, 16'hBEEF, good_ck(OP_READ, 8'h22, 16'hBEEF), 1'b1);
    verify("badck", 0, 0, 0);

    // Timeout after leading junk
    mark();
    send_byte(8'h00, 1'b0, 4, 1'b1);
    send_byte(8'hFF, 1'b0, 4, 1'b1);
    send_byte(SYNC_BYTE_DEF, 1'b0, 4, 1'b0);
    rx_data = OP_WRITE;
    rx_data_rdy = 1'b1;
    step();
    ticks = 0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      step();
      if (c == 29) rx_data_rdy = 1'b0;
      if (baud_x16_en) ticks++;
      if (err_timeout) begin
        seen = 1'b1;
        chk("to.busy", 32'(busy), 32'd0);
      end
    end
    rx_data_rdy = 1'b0;
    chk("to.seen", 32'(seen), 32'd1);
    chk("to.ticks", 32'(ticks), 32'd480);
    repeat (10) step();
    verify("to", 0, 1, 0);

    // Framing error after DH, then after the checksum inside the stop wait
    mark();
    send_byte(SYNC_BYTE_DEF, 1'b0, 4, 1'b0);
    send_byte(8'h01, 1'b0, 4, 1'b0);
    send_byte(8'h10, 1'b0, 4, 1'b0);
    send_byte(8'h12, 1'b1, 4, 1'b0);
    send_byte(8'h34, 1'b0, 4, 1'b1);
    send_byte(8'hA9, 1'b0, 60, 1'b1);
    send_byte(SYNC_BYTE_DEF, 1'b0, 4, 1'b0);
    send_byte(8'h01, 1'b0, 4, 1'b0);
    send_byte(8'h10, 1'b0, 4, 1'b0);
    send_byte(8'h12, 1'b0, 4, 1'b0);
    send_byte(8'h34, 1'b0, 4, 1'b0);
    send_byte(8'hA9, 1'b1, 60, 1'b0);
    verify("frame", 2, 0, 0);

    // Backpressure: packet held while three more bytes arrive
    mark();
    cmd_ready = 1'b0;
    send_pkt(8'h5C, 8'h7E, 16'hC3A1, good_ck(8'h5C, 8'h7E, 16'hC3A1), 1'b1);
    chk("bp.valid", 32'(cmd_valid), 32'd1);
    chk("bp.fields", {cmd_op, cmd_addr, cmd_wdata}, 32'h5C7E_C3A1);
    hold_snap = 32'h5C7E_C3A1;
    hold_watch = 1'b1;
    send_byte(SYNC_BYTE_DEF, 1'b0, 10, 1'b0);
    send_byte(8'h55, 1'b0, 10, 1'b0);
    send_byte(8'h00, 1'b0, 10, 1'b0);
    repeat (1500) step();
    hold_watch = 1'b0;
    chk("bp.stable", 32'(cnt_unstable), 32'd0);
    chk("bp.none_early", 32'(got_q.size()), 32'd0);
    cmd_ready = 1'b1;
    repeat (5) step();
    chk("bp.drop", 32'(cmd_valid), 32'd0);
    verify("bp", 0, 0, 3);

    // Asynchronous reset while in DL
    mark();
    send_byte(SYNC_BYTE_DEF, 1'b0, 4, 1'b0);
    send_byte(8'h01, 1'b0, 4, 1'b0);
    send_byte(8'h10, 1'b0, 4, 1'b0);
    send_byte(8'h12, 1'b0, 4, 1'b0);
    chk("rstdl.busy_before", 32'(busy), 32'd1);
    step();
    #2;
    rst_clk_rx_n = 1'b0;
    #1;
    chk("rstdl.outs", {cmd_valid, busy, err_frame, err_timeout, err_cksum, err_overrun}, 32'd0);
    chk("rstdl.fields", {cmd_op, cmd_addr, cmd_wdata}, 32'd0);
    repeat (3) step();
    rst_clk_rx_n = 1'b1;
    repeat (3) step();
    mark();
    send_pkt(OP_STATUS, 8'h44, 16'h0F0F, good_ck(OP_STATUS, 8'h44, 16'h0F0F), 1'b1);
    verify("rstdl", 0, 0, 0);

    // Random packets with junk and occasional bad checksums
    mark();
    for (int p = 0; p < 12; p++) begin
      for (int j = 0; j < int'($urandom_range(2, 0)); j++)
        send_byte(8'($urandom_range(8'hA4, 8'h00)), 1'b0, int'($urandom_range(20, 0)), 1'b1);
      op = 8'($urandom);
      ad = 8'($urandom);
      wd = 16'($urandom);
      ck = good_ck(op, ad, wd);
      if ($urandom_range(2, 0) == 0) ck = ck + 8'($urandom_range(255, 1));
      send_byte(SYNC_BYTE_DEF, 1'b0, int'($urandom_range(20, 0)), 1'b1);
      send_byte(op, 1'b0, int'($urandom_range(20, 0)), 1'b1);
      send_byte(ad, 1'b0, int'($urandom_range(20, 0)), 1'b1);
      send_byte(wd[15:8], 1'b0, int'($urandom_range(20, 0)), 1'b1);
      send_byte(wd[7:0], 1'b0, int'($urandom_range(20, 0)), 1'b1);
      send_byte(ck, 1'b0, 60, 1'b1);
    end
    verify("rand", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
